// File: rtl/int_div_pkg.sv
// Shared types and helpers for the sequential signed divider.
package int_div_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;

  // Two's-complement magnitude; callers sign-extend into 64 bits and truncate the result.
  function automatic logic [63:0] abs_val(input logic signed [63:0] v);
    return v[63] ? 64'(-v) : 64'(v);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract, keep or restore.
module div_step #(
  parameter int unsigned N = 32
) (
  input  logic [N:0]   i_prem,
  input  logic         i_msb,
  input  logic [N-1:0] i_divisor,
  output logic [N:0]   o_prem,
  output logic         o_qbit
);

  logic [N+1:0] w_shift;
  logic [N+1:0] w_diff;

  assign w_shift = {i_prem, i_msb};
  assign w_diff  = w_shift - {2'b00, i_divisor};
  assign o_qbit  = ~w_diff[N+1];
  assign o_prem  = o_qbit ? w_diff[N:0] : w_shift[N:0];

endmodule

// File: rtl/integer_divider_seq.sv
// Sequential signed N-bit divider: radix-2 restoring on magnitudes, sign fix-up on entry to DONE.
module integer_divider_seq
  import int_div_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [N-1:0] i_int_dividend,
  input  logic [N-1:0] i_int_divisor,
  output logic         o_busy,
  output logic         o_done,
  output logic [N-1:0] o_int_quotient,
  output logic [N-1:0] o_int_remainder,
  output logic         o_flag_div_zero,
  output logic         o_flag_overflow
);

  localparam int unsigned CntW = $clog2(N) + 1;
  localparam logic [CntW-1:0] LastIter = CntW'(N - 1);

  div_state_t r_state, w_state_next;

  logic [N:0]      r_prem;
  logic [N-1:0]    r_a;     // dividend magnitude, shifted out while quotient bits shift in
  logic [N-1:0]    r_b;
  logic [CntW-1:0] r_cnt;
  logic            r_qneg, r_rneg, r_ovf;
  logic [N-1:0]    r_quot, r_rem;
  logic            r_fdz, r_fovf;

  logic         w_accept, w_div0, w_last, w_qbit;
  logic [N:0]   w_prem_next;
  logic [N-1:0] w_qmag, w_rmag;

  assign w_accept = i_start && (r_state != CALC);
  assign w_div0   = (i_int_divisor == '0);
  assign w_last   = (r_cnt == LastIter);
  assign w_qmag   = {r_a[N-2:0], w_qbit};
  assign w_rmag   = w_prem_next[N-1:0];

  div_step #(.N(N)) u_step (
    .i_prem    (r_prem),
    .i_msb     (r_a[N-1]),
    .i_divisor (r_b),
    .o_prem    (w_prem_next),
    .o_qbit    (w_qbit)
  );

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE, DONE: begin
        if (w_accept) begin
          w_state_next = w_div0 ? DONE : CALC;
        end else begin
          w_state_next = IDLE;
        end
      end
      CALC: begin
        if (w_last) begin
          w_state_next = DONE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_prem  <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_cnt   <= '0;
      r_qneg  <= 1'b0;
      r_rneg  <= 1'b0;
      r_ovf   <= 1'b0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_fdz   <= 1'b0;
      r_fovf  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_a    <= N'(abs_val(64'($signed(i_int_dividend))));
        r_b    <= N'(abs_val(64'($signed(i_int_divisor))));
        r_prem <= '0;
        r_cnt  <= '0;
        r_qneg <= i_int_dividend[N-1] ^ i_int_divisor[N-1];
        r_rneg <= i_int_dividend[N-1];
        r_ovf  <= (i_int_dividend == {1'b1, {(N-1){1'b0}}}) && (&i_int_divisor);
        r_fovf <= 1'b0;
        // Divide-by-zero skips CALC, so its results land on the accepting edge itself.
        if (w_div0) begin
          r_quot <= '1;
          r_rem  <= i_int_dividend;
          r_fdz  <= 1'b1;
        end else begin
          r_quot <= '0;
          r_rem  <= '0;
          r_fdz  <= 1'b0;
        end
      end else if (r_state == CALC) begin
        r_prem <= w_prem_next;
        r_a    <= w_qmag;
        r_cnt  <= r_cnt + CntW'(1);
        if (w_last) begin
          r_quot <= r_qneg ? -w_qmag : w_qmag;
          r_rem  <= r_rneg ? -w_rmag : w_rmag;
          r_fovf <= r_ovf;
        end
      end
    end
  end

  assign o_busy          = (r_state == CALC);
  assign o_done          = (r_state == DONE);
  assign o_int_quotient  = r_quot;
  assign o_int_remainder = r_rem;
  assign o_flag_div_zero = r_fdz;
  assign o_flag_overflow = r_fovf;

endmodule

// File: tb/tb_integer_divider_seq.sv
// Scoreboard bench for integer_divider_seq (N=8): directed corner cases plus random operands.
module tb_integer_divider_seq;

  localparam int unsigned N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] dvd, dvs;
  logic         busy, done;
  logic [N-1:0] quo, rem;
  logic         fdz, fov;

  integer_divider_seq #(.N(N)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_start         (start),
    .i_int_dividend  (dvd),
    .i_int_divisor   (dvs),
    .o_busy          (busy),
    .o_done          (done),
    .o_int_quotient  (quo),
    .o_int_remainder (rem),
    .o_flag_div_zero (fdz),
    .o_flag_overflow (fov)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    logic       ov;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // Reference: plain integer division (truncates toward zero, remainder follows dividend).
  function automatic exp_t model(input int a, input int b);
    exp_t e;
    int   q, r;
    e = '0;
    if (b == 0) begin
      e.q  = 8'hFF;
      e.r  = 8'(a);
      e.dz = 1'b1;
    end else if (a == -128 && b == -1) begin
      e.q  = 8'h80;
      e.r  = 8'h00;
      e.ov = 1'b1;
    end else begin
      q   = a / b;
      r   = a % b;
      e.q = 8'(q);
      e.r = 8'(r);
    end
    return e;
  endfunction

  function automatic int pick();
    logic signed [7:0] t;
    case ($urandom_range(0, 5))
      0:       return 0;
      1:       return -128;
      2:       return -1;
      3:       return 1;
      default: begin
        t = 8'($urandom);
        return int'(t);
      end
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && done) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: q=0x%0h r=0x%0h with no request outstanding", quo, rem);
      end else begin
        e = sb.pop_front();
        check("quotient", 32'(quo), 32'(e.q));
        check("remainder", 32'(rem), 32'(e.r));
        check("flag_div_zero", 32'(fdz), 32'(e.dz));
        check("flag_overflow", 32'(fov), 32'(e.ov));
        check("busy_low_in_done", 32'(busy), 32'(0));
      end
    end
  end

  task automatic do_div(input int a, input int b, input string tag);
    int   lat;
    int   busy_cnt;
    exp_t e;
    e = model(a, b);
    @(negedge clk);
    dvd   = 8'(a);
    dvs   = 8'(b);
    start = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    start    = 1'b0;
    lat      = 1;
    busy_cnt = 0;
    while (!done && lat < 20) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 32'(lat), (b == 0) ? 32'(1) : 32'(N + 1));
    check({tag, " busy_cycles"}, 32'(busy_cnt), (b == 0) ? 32'(0) : 32'(N));
    @(negedge clk);
    check({tag, " done_one_cycle"}, 32'(done), 32'(0));
    check({tag, " held_quotient"}, 32'(quo), 32'(e.q));
    check({tag, " held_remainder"}, 32'(rem), 32'(e.r));
  endtask

  initial begin
    int cyc, first, second, dcount, lat;
    rst   = 1'b1;
    start = 1'b0;
    dvd   = '0;
    dvs   = '0;
    repeat (2) @(negedge clk);
    check("reset busy", 32'(busy), 32'(0));
    check("reset done", 32'(done), 32'(0));
    check("reset quotient", 32'(quo), 32'(0));
    check("reset remainder", 32'(rem), 32'(0));
    check("reset flags", 32'({fdz, fov}), 32'(0));
    rst = 1'b0;

    do_div(100, 7, "100/7");
    do_div(-100, 7, "-100/7");
    do_div(100, -7, "100/-7");
    do_div(-100, -7, "-100/-7");
    do_div(100, 0, "100/0");
    do_div(-128, -1, "-128/-1");
    do_div(-128, 1, "-128/1");
    do_div(0, 5, "0/5");
    do_div(127, -128, "127/-128");

    // Start while busy must not disturb operands or results.
    @(negedge clk);
    dvd   = 8'(50);
    dvs   = 8'(3);
    start = 1'b1;
    sb.push_back(model(50, 3));
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    dvd   = 8'(9);
    dvs   = 8'(2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 3;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("ignored_start latency", 32'(lat), 32'(N + 1));
    @(negedge clk);

    // Reset mid-CALC, with start also high on the reset edge (reset wins).
    @(negedge clk);
    dvd   = 8'(100);
    dvs   = 8'(7);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_reset busy", 32'(busy), 32'(1));
    rst   = 1'b1;
    start = 1'b1;
    dvs   = 8'(0);
    @(negedge clk);
    check("mid_reset busy", 32'(busy), 32'(0));
    check("mid_reset done", 32'(done), 32'(0));
    check("mid_reset quotient", 32'(quo), 32'(0));
    check("mid_reset remainder", 32'(rem), 32'(0));
    check("mid_reset flags", 32'({fdz, fov}), 32'(0));
    rst    = 1'b0;
    start  = 1'b0;
    dcount = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("aborted_no_done", 32'(dcount), 32'(0));

    // Back-to-back: start held through DONE, operands changed while busy.
    @(negedge clk);
    dvd   = 8'(20);
    dvs   = 8'(4);
    start = 1'b1;
    sb.push_back(model(20, 4));
    @(negedge clk);
    dvd = 8'(21);
    dvs = 8'(4);
    sb.push_back(model(21, 4));
    cyc    = 1;
    first  = -1;
    second = -1;
    while (cyc < 40 && second < 0) begin
      if (done) begin
        if (first < 0) first = cyc;
        else second = cyc;
      end
      if (first >= 0 && cyc == first + 1) begin
        check("b2b busy_after_done", 32'(busy), 32'(1));
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    check("b2b first_done", 32'(first), 32'(N + 1));
    check("b2b done_spacing", 32'(second - first), 32'(N + 1));
    start = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 150; i++) begin
      do_div(pick(), pick(), "rand");
    end

    cyc = 0;
    while (sb.size() != 0 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("scoreboard_drained", 32'(sb.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
